// File: rtl/gate_driver_pkg.sv
// rtl/gate_driver_pkg.sv - leg state encoding, command decode and counter width default
// Shared by gate_leg_fsm and gate_deadtime_driver.
package gate_driver_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEAD    = 3'd1,
    ST_HIGH_ON = 3'd2,
    ST_LOW_ON  = 3'd3,
    ST_FAULT   = 3'd4
  } leg_state_e;

  // Leg command is {high_side, low_side}
  localparam logic [1:0] CMD_OFF     = 2'b00;
  localparam logic [1:0] CMD_LOW     = 2'b01;
  localparam logic [1:0] CMD_HIGH    = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

endpackage

// File: rtl/gate_leg_fsm.sv
// rtl/gate_leg_fsm.sv - dead-time FSM for one half-bridge leg
// Minimum on-time hold is built only when GATE_DRIVER_MIN_ON_EN is defined.
module gate_leg_fsm
  import gate_driver_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int MIN_ON   = 16,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       en,
  input  logic [1:0] cmd,
  output logic       gate_hi,
  output logic       gate_lo,
  output logic       busy,
  output logic       fault,
  output leg_state_e state
);

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME - 1);

  leg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_done;

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fault outranks disable, which outranks normal sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cmd == CMD_ILLEGAL || state_q == ST_FAULT) begin
      state_d = ST_FAULT;
    end else if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd != CMD_OFF) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (cmd == CMD_HIGH) begin
            state_d = ST_HIGH_ON;
          end else if (cmd == CMD_LOW) begin
            state_d = ST_LOW_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HIGH_ON: begin
          if (on_done && cmd == CMD_LOW) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end else if (on_done && cmd == CMD_OFF) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOW_ON: begin
          if (on_done && cmd == CMD_HIGH) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end else if (on_done && cmd == CMD_OFF) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

`ifdef GATE_DRIVER_MIN_ON_EN
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON - 1);
  logic [CNT_W-1:0] on_cnt_q;

  assign on_done = (on_cnt_q >= ON_LAST);

  // Restarts on every state change, so it counts from entry into an on state
  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      on_cnt_q <= '0;
    end else if (state_d != state_q) begin
      on_cnt_q <= '0;
    end else if (!on_done) begin
      on_cnt_q <= on_cnt_q + CNT_W'(1);
    end
  end
`else
  assign on_done = 1'b1;
`endif

  assign gate_hi = (state_q == ST_HIGH_ON);
  assign gate_lo = (state_q == ST_LOW_ON);
  assign busy    = (state_q == ST_DEAD);
  assign fault   = (state_q == ST_FAULT);
  assign state   = state_q;

  a_deadtime_range: assert property (@(posedge i_clock)
    (DEADTIME >= 1) && (DEADTIME < (1 << CNT_W)));
  a_min_on_range: assert property (@(posedge i_clock)
    (MIN_ON >= 1) && (MIN_ON < (1 << CNT_W)));

endmodule

// File: rtl/gate_deadtime_driver.sv
// rtl/gate_deadtime_driver.sv - two-leg gate driver with dead-time insertion and shoot-through fault
// Minimum on-time per leg is enabled by GATE_DRIVER_MIN_ON_EN.
module gate_deadtime_driver
  import gate_driver_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int MIN_ON   = 16,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [3:0] i_MOSFET,
  output logic [3:0] o_gate,
  output logic       o_fault,
  output logic       o_busy,
  output logic [7:0] o_debug
);

  logic [3:0] cmd_q;
  logic       en_q;
  logic       a_hi, a_lo, a_busy, a_fault;
  logic       b_hi, b_lo, b_busy, b_fault;
  leg_state_e a_state, b_state;

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      cmd_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cmd_q <= i_MOSFET;
      en_q  <= i_enable;
    end
  end

  // Leg A: [0] high, [2] low; leg B: [1] high, [3] low
  gate_leg_fsm #(.DEADTIME(DEADTIME), .MIN_ON(MIN_ON), .CNT_W(CNT_W)) u_leg_a (
    .i_clock (i_clock),
    .i_RESET (i_RESET),
    .en      (en_q),
    .cmd     ({cmd_q[0], cmd_q[2]}),
    .gate_hi (a_hi),
    .gate_lo (a_lo),
    .busy    (a_busy),
    .fault   (a_fault),
    .state   (a_state)
  );

  gate_leg_fsm #(.DEADTIME(DEADTIME), .MIN_ON(MIN_ON), .CNT_W(CNT_W)) u_leg_b (
    .i_clock (i_clock),
    .i_RESET (i_RESET),
    .en      (en_q),
    .cmd     ({cmd_q[1], cmd_q[3]}),
    .gate_hi (b_hi),
    .gate_lo (b_lo),
    .busy    (b_busy),
    .fault   (b_fault),
    .state   (b_state)
  );

  assign o_gate  = {b_lo, a_lo, b_hi, a_hi};
  assign o_fault = a_fault | b_fault;
  assign o_busy  = a_busy | b_busy;
  assign o_debug = {b_state, a_state, o_fault, o_busy};

endmodule

// File: tb/tb_gate_deadtime_driver.sv
// tb/tb_gate_deadtime_driver.sv - self-checking bench for gate_deadtime_driver
module tb_gate_deadtime_driver;

  localparam int DT = 8;
`ifdef GATE_DRIVER_MIN_ON_EN
  localparam int MIN_ON_EFF = 16;
  localparam int S6_FIRST   = 11;
  localparam int S6_ONTOT   = 16;
`else
  localparam int MIN_ON_EFF = 1;
  localparam int S6_FIRST   = 1;
  localparam int S6_ONTOT   = 6;
`endif

  logic       i_clock;
  logic       i_RESET;
  logic       i_enable;
  logic [3:0] i_MOSFET;
  logic [3:0] o_gate;
  logic       o_fault;
  logic       o_busy;
  logic [7:0] o_debug;

  gate_deadtime_driver #(.DEADTIME(DT), .MIN_ON(16), .CNT_W(8)) dut (
    .i_clock  (i_clock),
    .i_RESET  (i_RESET),
    .i_enable (i_enable),
    .i_MOSFET (i_MOSFET),
    .o_gate   (o_gate),
    .o_fault  (o_fault),
    .o_busy   (o_busy),
    .o_debug  (o_debug)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: per leg, which gate is on (0 none, 1 high, 2 low), how long in dead time, how long on
  int         m_cur[2];
  int         m_dead[2];
  int         m_on[2];
  bit         m_flt[2];
  logic [3:0] m_cmd;
  logic       m_en;

  task automatic model_edge(input logic [3:0] mos, input logic en, input logic rst);
    for (int l = 0; l < 2; l++) begin
      logic [1:0] c;
      int want;
      c = {m_cmd[l], m_cmd[l+2]};
      want = (c == 2'b10) ? 1 : (c == 2'b01) ? 2 : 0;
      if (rst) begin
        m_cur[l] = 0; m_dead[l] = -1; m_flt[l] = 0; m_on[l] = 0;
      end else if (c == 2'b11 || m_flt[l]) begin
        m_flt[l] = 1; m_cur[l] = 0; m_dead[l] = -1;
      end else if (!m_en) begin
        m_cur[l] = 0; m_dead[l] = -1;
      end else if (m_dead[l] >= 0) begin
        m_dead[l]++;
        if (m_dead[l] == DT) begin
          m_dead[l] = -1; m_cur[l] = want; m_on[l] = 1;
        end
      end else if (m_cur[l] == 0) begin
        if (want != 0) m_dead[l] = 0;
      end else if (want != m_cur[l] && m_on[l] >= MIN_ON_EFF) begin
        m_cur[l] = 0;
        if (want != 0) m_dead[l] = 0;
      end else begin
        m_on[l]++;
      end
    end
    if (rst) begin
      m_cmd = '0; m_en = 1'b0;
    end else begin
      m_cmd = mos; m_en = en;
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] g;
    logic [2:0] st[2];
    logic       b, f;
    g = '0; b = 1'b0; f = 1'b0;
    for (int l = 0; l < 2; l++) begin
      g[l]   = (m_cur[l] == 1);
      g[l+2] = (m_cur[l] == 2);
      b = b | (m_dead[l] >= 0);
      f = f | m_flt[l];
      st[l] = m_flt[l] ? 3'd4 : (m_dead[l] >= 0) ? 3'd1 : (m_cur[l] == 1) ? 3'd2 : (m_cur[l] == 2) ? 3'd3 : 3'd0;
    end
    return {st[1], st[0], f, b, g};
  endfunction

  task automatic tick(input logic [3:0] mos, input logic en, input logic rst);
    @(negedge i_clock);
    i_MOSFET = mos; i_enable = en; i_RESET = rst;
    @(posedge i_clock);
    model_edge(mos, en, rst);
    #1;
  endtask

  function automatic logic [1:0] rand_leg();
    int r;
    r = $urandom_range(0, 59);
    if (r == 0) return 2'b11;
    case (r % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  typedef struct {
    logic [3:0] mos;
    logic       en;
    logic       rst;
    int         reps;
    logic [3:0] gate;
    logic       busy;
    logic       fault;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] sigma[4];
  logic [3:0] prev;
  logic [1:0] la, lb;
  logic       hi, lo, ren;
  int         low_run[2];
  int         shoot, dviol, edges, rise, bcnt, ontot, hold;

  initial begin
    i_RESET = 1'b1; i_enable = 1'b0; i_MOSFET = '0;
    m_cmd = '0; m_en = 1'b0;
    for (int l = 0; l < 2; l++) begin
      m_cur[l] = 0; m_dead[l] = -1; m_on[l] = 0; m_flt[l] = 0;
    end

    vecs[0]  = '{4'b0000, 1'b0, 1'b1,  2, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b1, 1'b0,  1, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{4'b0001, 1'b1, 1'b0,  8, 4'b0000, 1'b1, 1'b0};
    vecs[3]  = '{4'b0001, 1'b1, 1'b0, 16, 4'b0001, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0,  1, 4'b0001, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0,  2, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0100, 1'b1, 1'b0,  1, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 1'b1, 1'b0,  8, 4'b0000, 1'b1, 1'b0};
    vecs[8]  = '{4'b0100, 1'b1, 1'b0,  2, 4'b0100, 1'b0, 1'b0};
    vecs[9]  = '{4'b1100, 1'b1, 1'b0,  1, 4'b0100, 1'b0, 1'b0};
    vecs[10] = '{4'b1100, 1'b1, 1'b0,  8, 4'b0100, 1'b1, 1'b0};
    vecs[11] = '{4'b1100, 1'b1, 1'b0,  1, 4'b1100, 1'b0, 1'b0};
    vecs[12] = '{4'b1101, 1'b1, 1'b0,  1, 4'b1100, 1'b0, 1'b0};
    vecs[13] = '{4'b1101, 1'b1, 1'b0,  2, 4'b1000, 1'b0, 1'b1};
    vecs[14] = '{4'b1000, 1'b1, 1'b0,  2, 4'b1000, 1'b0, 1'b1};
    vecs[15] = '{4'b1000, 1'b1, 1'b1,  1, 4'b0000, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        tick(vecs[i].mos, vecs[i].en, vecs[i].rst);
        check($sformatf("vec%0d_%0d", i, r), {o_gate, o_busy, o_fault},
              {vecs[i].gate, vecs[i].busy, vecs[i].fault});
      end
    end

    // Leg A low -> high transition latency and dead-time length
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 25; k++) tick(4'b0100, 1'b1, 1'b0);
    check("s1_low_on", o_gate, 4'b0100);
    tick(4'b0001, 1'b1, 1'b0);
    check("s1_low_holds_at_N", o_gate[2], 1'b1);
    rise = -1; bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0001, 1'b1, 1'b0);
      if (k == 1) check("s1_low_falls_N1", o_gate[2], 1'b0);
      if (o_gate[0] && rise < 0) rise = k;
      bcnt += int'(o_busy);
    end
    check("s1_high_rise_edge", rise, DT + 1);
    check("s1_busy_cycles", bcnt, DT);

    // Sigma cycle with no shoot-through and full dead time before every on-edge
    sigma[0] = 4'b1001; sigma[1] = 4'b0011; sigma[2] = 4'b0110; sigma[3] = 4'b0011;
    tick(4'b0000, 1'b1, 1'b1);
    low_run[0] = 0; low_run[1] = 0; prev = '0; shoot = 0; dviol = 0; edges = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) begin
        hold = (r == 0) ? 12 : int'($urandom_range(4, 14));
        for (int c = 0; c < hold; c++) begin
          tick(sigma[p], 1'b1, 1'b0);
          check("sigma_model", {o_debug, o_gate}, model_out());
          for (int l = 0; l < 2; l++) begin
            hi = o_gate[l]; lo = o_gate[l+2];
            if (hi && lo) shoot++;
            if ((hi && !prev[l]) || (lo && !prev[l+2])) begin
              edges++;
              if (low_run[l] < DT) dviol++;
            end
            if (!hi && !lo) low_run[l]++;
            else low_run[l] = 0;
          end
          prev = o_gate;
        end
      end
    end
    check("sigma_shoot_through", shoot, 0);
    check("sigma_dead_violations", dviol, 0);
    check("sigma_on_edges_seen", edges > 0, 1);

    // Illegal command on leg B while high-side on
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick(4'b0010, 1'b1, 1'b0);
    check("s3_b_high_on", o_gate, 4'b0010);
    tick(4'b1010, 1'b1, 1'b0);
    check("s3_before_fault", {o_gate, o_fault}, {4'b0010, 1'b0});
    tick(4'b1010, 1'b1, 1'b0);
    check("s3_fault_gates_off", {o_gate[3], o_gate[1], o_fault}, 3'b001);
    for (int k = 0; k < 5; k++) tick(4'b0010, 1'b1, 1'b0);
    check("s3_fault_sticky", {o_gate[3], o_gate[1], o_fault, o_debug[7:5]}, {3'b001, 3'd4});
    tick(4'b0010, 1'b1, 1'b1);
    check("s3_fault_cleared_by_reset", o_fault, 1'b0);

    // Enable dropped during LOW_ON, then restored with command low
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick(4'b0100, 1'b1, 1'b0);
    check("s4_low_on", o_gate, 4'b0100);
    tick(4'b0100, 1'b0, 1'b0);
    check("s4_drop_edge1", o_gate, 4'b0100);
    tick(4'b0100, 1'b0, 1'b0);
    check("s4_drop_edge2_off", {o_gate, o_busy}, 5'b00000);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0100, 1'b1, 1'b0);
    check("s4_return_edge", {o_gate, o_busy}, 5'b00000);
    rise = -1; bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0100, 1'b1, 1'b0);
      if (o_gate[2] && rise < 0) rise = k;
      bcnt += int'(o_busy);
    end
    check("s4_low_rise_edge", rise, DT + 1);
    check("s4_busy_cycles", bcnt, DT);
    check("s4_no_fault", o_fault, 1'b0);

    // Reset in the 4th dead-time cycle
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(4'b0001, 1'b1, 1'b0);
    check("s5_in_dead", {o_gate, o_busy}, 5'b00001);
    tick(4'b0001, 1'b1, 1'b1);
    check("s5_reset_clears", {o_debug, o_gate}, 12'h000);
    tick(4'b0001, 1'b1, 1'b0);
    check("s5_idle_after_reset", o_debug, 8'h00);
    rise = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0001, 1'b1, 1'b0);
      if (o_gate[0] && rise < 0) rise = k;
    end
    check("s5_restart_rise_edge", rise, DT + 1);

    // Toggle after 5 on-cycles: minimum on-time defers the exit when enabled
    tick(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick(4'b0001, 1'b1, 1'b0);
    check("s6_high_on", o_gate, 4'b0001);
    for (int k = 0; k < 4; k++) tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0100, 1'b1, 1'b0);
    rise = -1; ontot = 6;
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0100, 1'b1, 1'b0);
      if (o_busy && rise < 0) rise = k;
      ontot += int'(o_gate[0]);
    end
    check("s6_dead_entry_edge", rise, S6_FIRST);
    check("s6_high_on_cycles", ontot, S6_ONTOT);

    // Randomized traffic against the reference
    tick(4'b0000, 1'b0, 1'b1);
    for (int blk = 0; blk < 80; blk++) begin
      la = rand_leg(); lb = rand_leg();
      ren = ($urandom_range(0, 19) != 0);
      hold = int'($urandom_range(1, 14));
      for (int c = 0; c < hold; c++) begin
        tick({lb[0], la[0], lb[1], la[1]}, ren, ($urandom_range(0, 99) == 0));
        check("rand_model", {o_debug, o_gate}, model_out());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
